// File: rtl/bp_pht_ctrl.sv
// rtl/bp_pht_ctrl.sv - 2-bit PHT branch predictor controller: init sweep, IF lookup, ID resolve/update
// Optional statistics counters (mispred_cnt, branch_cnt) are enabled by defining BP_STATS_EN.
module bp_pht_ctrl #(
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  INIT_CNT = 2'b10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              if_branch,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_pc_add_imm,
  input  logic              id_branch,
  input  logic              id_taken,
  output logic              pred_taken,
  output logic [31:0]       next_pc,
  output logic              mispredict,
  output logic              busy
`ifdef BP_STATS_EN
  ,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic [CNT_W-1:0]  branch_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         pht_q [DEPTH];
  logic [1:0]         pht_d [DEPTH];

  logic               rec_valid_q, rec_valid_d;
  logic [IDX_W-1:0]   rec_idx_q, rec_idx_d;
  logic               rec_pred_q, rec_pred_d;
  logic [1:0]         rec_ctr_q, rec_ctr_d;
  logic [31:0]        rec_alt_q, rec_alt_d;

  logic               pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
  logic [1:0]         pend_ctr_q, pend_ctr_d;

  logic               run;
  logic [31:0]        pc_plus4;
  logic [IDX_W-1:0]   lk_idx;
  logic [1:0]         lk_ctr;
  logic               pred;
  logic               resolve;
  logic               mis;
  logic               capture;
  logic [1:0]         new_ctr;

  // Lookup sees the not-yet-written pending update so back-to-back use of an index is coherent.
  always_comb begin
    run      = (state_q == S_RUN);
    pc_plus4 = if_pc + 32'd4;
    lk_idx   = if_pc[IDX_W+1:2];
    lk_ctr   = (pend_valid_q && (pend_idx_q == lk_idx)) ? pend_ctr_q : pht_q[lk_idx];
    pred     = run & if_branch & lk_ctr[1];
    resolve  = run & id_branch & ~stall & rec_valid_q;
    mis      = resolve & (rec_pred_q != id_taken);
    capture  = run & if_branch & ~stall & ~mis;
    if (id_taken) begin
      new_ctr = (rec_ctr_q == 2'b11) ? 2'b11 : rec_ctr_q + 2'd1;
    end else begin
      new_ctr = (rec_ctr_q == 2'b00) ? 2'b00 : rec_ctr_q - 2'd1;
    end
    if (!run || stall) begin
      next_pc = pc_plus4;
    end else if (mis) begin
      next_pc = rec_alt_q;
    end else if (pred) begin
      next_pc = if_pc_add_imm;
    end else begin
      next_pc = pc_plus4;
    end
  end

  assign pred_taken = pred;
  assign mispredict = mis;
  assign busy       = ~run;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pht_d        = pht_q;
    rec_valid_d  = rec_valid_q;
    rec_idx_d    = rec_idx_q;
    rec_pred_d   = rec_pred_q;
    rec_ctr_d    = rec_ctr_q;
    rec_alt_d    = rec_alt_q;
    pend_valid_d = 1'b0;
    pend_idx_d   = pend_idx_q;
    pend_ctr_d   = pend_ctr_q;
    case (state_q)
      S_INIT: begin
        pht_d[ptr_q] = INIT_CNT;
        ptr_d        = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (pend_valid_q) begin
          pht_d[pend_idx_q] = pend_ctr_q;
        end
        if (resolve) begin
          pend_valid_d = 1'b1;
          pend_idx_d   = rec_idx_q;
          pend_ctr_d   = new_ctr;
          rec_valid_d  = 1'b0;
        end
        // A capture in the same cycle as a correct resolve keeps the record alive.
        if (capture) begin
          rec_valid_d = 1'b1;
          rec_idx_d   = lk_idx;
          rec_pred_d  = pred;
          rec_ctr_d   = lk_ctr;
          rec_alt_d   = pred ? pc_plus4 : if_pc_add_imm;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      ptr_q        <= '0;
      rec_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rec_valid_q  <= rec_valid_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    pht_q      <= pht_d;
    rec_idx_q  <= rec_idx_d;
    rec_pred_q <= rec_pred_d;
    rec_ctr_q  <= rec_ctr_d;
    rec_alt_q  <= rec_alt_d;
    pend_idx_q <= pend_idx_d;
    pend_ctr_q <= pend_ctr_d;
  end

`ifdef BP_STATS_EN
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mis && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// tb/tb_bp_pht_ctrl.sv - scoreboard bench for bp_pht_ctrl (IDX_W=4)
module tb_bp_pht_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        if_branch = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic [31:0] if_pc_add_imm = 32'h0;
  logic        id_branch = 1'b0;
  logic        id_taken = 1'b0;
  logic        pred_taken;
  logic [31:0] next_pc;
  logic        mispredict;
  logic        busy;
`ifdef BP_STATS_EN
  logic [15:0] mispred_cnt;
  logic [15:0] branch_cnt;
`endif

  bp_pht_ctrl #(.IDX_W(4), .INIT_CNT(2'b10), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .if_branch     (if_branch),
    .if_pc         (if_pc),
    .if_pc_add_imm (if_pc_add_imm),
    .id_branch     (id_branch),
    .id_taken      (id_taken),
    .pred_taken    (pred_taken),
    .next_pc       (next_pc),
    .mispredict    (mispredict),
    .busy          (busy)
`ifdef BP_STATS_EN
    ,
    .mispred_cnt   (mispred_cnt),
    .branch_cnt    (branch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifb;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        idb;
    logic        idt;
    logic        stl;
    logic        e_pred;
    logic [31:0] e_npc;
    logic        e_mis;
    logic        e_busy;
  } step_t;

  step_t exp_q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic step_t mk(logic ifb, logic [31:0] pc, logic [31:0] imm, logic idb, logic idt,
                               logic stl, logic e_pred, logic [31:0] e_npc, logic e_mis, logic e_busy);
    step_t s;
    s.ifb = ifb; s.pc = pc; s.imm = imm; s.idb = idb; s.idt = idt; s.stl = stl;
    s.e_pred = e_pred; s.e_npc = e_npc; s.e_mis = e_mis; s.e_busy = e_busy;
    return s;
  endfunction

  task automatic drive_step(input step_t s);
    if_branch     = s.ifb;
    if_pc         = s.pc;
    if_pc_add_imm = s.imm;
    id_branch     = s.idb;
    id_taken      = s.idt;
    stall         = s.stl;
    exp_q.push_back(s);
  endtask

  task automatic test_reset;
    step_t tbl[$];
    step_t e;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) tbl.push_back(mk(1, 32'h100, 32'h500, 1, 1, k[0], 0, 32'h104, 0, 1));
    tbl.push_back(mk(0, 32'h100, 32'h500, 0, 0, 0, 0, 32'h104, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (busy !== e.e_busy) $display("FAIL reset[%0d] busy got %b exp %b", i, busy, e.e_busy); else passed++;
      checks++; if (pred_taken !== e.e_pred) $display("FAIL reset[%0d] pred_taken got %b exp %b", i, pred_taken, e.e_pred); else passed++;
      checks++; if (next_pc !== e.e_npc) $display("FAIL reset[%0d] next_pc got %h exp %h", i, next_pc, e.e_npc); else passed++;
      checks++; if (mispredict !== e.e_mis) $display("FAIL reset[%0d] mispredict got %b exp %b", i, mispredict, e.e_mis); else passed++;
`ifdef BP_STATS_EN
      checks++; if (branch_cnt !== 16'd0) $display("FAIL reset[%0d] branch_cnt got %0d exp 0", i, branch_cnt); else passed++;
      checks++; if (mispred_cnt !== 16'd0) $display("FAIL reset[%0d] mispred_cnt got %0d exp 0", i, mispred_cnt); else passed++;
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_init_values;
    step_t tbl[$];
    step_t e;
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(1, 32'(k) << 2, 32'h1000 + (32'(k) << 4), 0, 0, 0, 1, 32'h1000 + (32'(k) << 4), 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (busy !== e.e_busy) $display("FAIL init[%0d] busy got %b exp %b", i, busy, e.e_busy); else passed++;
      checks++; if (pred_taken !== e.e_pred) $display("FAIL init[%0d] pred_taken got %b exp %b", i, pred_taken, e.e_pred); else passed++;
      checks++; if (next_pc !== e.e_npc) $display("FAIL init[%0d] next_pc got %h exp %h", i, next_pc, e.e_npc); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispredict_saturate;
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 32'h40, 32'h80, 0, 0, 0, 1, 32'h80, 0, 0));
    tbl.push_back(mk(0, 32'h44, 32'h0,  1, 0, 0, 0, 32'h44, 1, 0));
    tbl.push_back(mk(1, 32'h40, 32'h80, 0, 0, 0, 0, 32'h44, 0, 0));
    tbl.push_back(mk(0, 32'h44, 32'h0,  1, 0, 0, 0, 32'h48, 0, 0));
    tbl.push_back(mk(1, 32'h40, 32'h80, 0, 0, 0, 0, 32'h44, 0, 0));
    tbl.push_back(mk(0, 32'h44, 32'h0,  1, 0, 0, 0, 32'h48, 0, 0));
    tbl.push_back(mk(1, 32'h40, 32'h80, 0, 0, 0, 0, 32'h44, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (pred_taken !== e.e_pred) $display("FAIL missat[%0d] pred_taken got %b exp %b", i, pred_taken, e.e_pred); else passed++;
      checks++; if (next_pc !== e.e_npc) $display("FAIL missat[%0d] next_pc got %h exp %h", i, next_pc, e.e_npc); else passed++;
      checks++; if (mispredict !== e.e_mis) $display("FAIL missat[%0d] mispredict got %b exp %b", i, mispredict, e.e_mis); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bypass;
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 0, 0, 0, 32'h18,  1, 0));
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 0, 32'h18,  0, 0));
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 1, 0, 0, 32'h200, 1, 0));
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 1, 0, 0, 32'h1c,  0, 0));
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 1, 0, 0, 32'h1c,  0, 0));
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 0, 0, 0, 32'h18,  1, 0));
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (pred_taken !== e.e_pred) $display("FAIL bypass[%0d] pred_taken got %b exp %b", i, pred_taken, e.e_pred); else passed++;
      checks++; if (next_pc !== e.e_npc) $display("FAIL bypass[%0d] next_pc got %h exp %h", i, next_pc, e.e_npc); else passed++;
      checks++; if (mispredict !== e.e_mis) $display("FAIL bypass[%0d] mispredict got %b exp %b", i, mispredict, e.e_mis); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 0, 1, 0, 32'h1c,  0, 0));
    tbl.push_back(mk(0, 32'h18, 32'h0,   1, 0, 0, 0, 32'h18,  1, 0));
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 0, 32'h18,  0, 0));
    tbl.push_back(mk(1, 32'h04, 32'h300, 0, 0, 1, 1, 32'h08,  0, 0));
    tbl.push_back(mk(0, 32'h08, 32'h0,   1, 1, 0, 0, 32'h200, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (pred_taken !== e.e_pred) $display("FAIL stall[%0d] pred_taken got %b exp %b", i, pred_taken, e.e_pred); else passed++;
      checks++; if (next_pc !== e.e_npc) $display("FAIL stall[%0d] next_pc got %h exp %h", i, next_pc, e.e_npc); else passed++;
      checks++; if (mispredict !== e.e_mis) $display("FAIL stall[%0d] mispredict got %b exp %b", i, mispredict, e.e_mis); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    step_t tbl[$];
    step_t e;
    tbl.push_back(mk(1, 32'h14, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h40, 32'h80,  1, 0, 0, 0, 32'h18,  1, 0));
    tbl.push_back(mk(0, 32'h44, 32'h0,   1, 1, 0, 0, 32'h48,  0, 0));
    tbl.push_back(mk(1, 32'h04, 32'h300, 0, 0, 0, 1, 32'h300, 0, 0));
    tbl.push_back(mk(1, 32'h08, 32'h400, 1, 1, 0, 1, 32'h400, 0, 0));
    tbl.push_back(mk(0, 32'h0c, 32'h0,   1, 0, 0, 0, 32'h0c,  1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (pred_taken !== e.e_pred) $display("FAIL b2b[%0d] pred_taken got %b exp %b", i, pred_taken, e.e_pred); else passed++;
      checks++; if (next_pc !== e.e_npc) $display("FAIL b2b[%0d] next_pc got %h exp %h", i, next_pc, e.e_npc); else passed++;
      checks++; if (mispredict !== e.e_mis) $display("FAIL b2b[%0d] mispredict got %b exp %b", i, mispredict, e.e_mis); else passed++;
      @(posedge clk); #1;
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats;
    if_branch = 1'b0;
    id_branch = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    checks++; if (branch_cnt !== 16'd13) $display("FAIL stats branch_cnt got %0d exp 13", branch_cnt); else passed++;
    checks++; if (mispred_cnt !== 16'd8) $display("FAIL stats mispred_cnt got %0d exp 8", mispred_cnt); else passed++;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_init_values();
    test_mispredict_saturate();
    test_bypass();
    test_stall();
    test_back_to_back();
`ifdef BP_STATS_EN
    test_stats();
`endif
    test_reset();
    test_init_values();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bp_pht_ctrl.md
Name: bp_pht_ctrl

Overview:
Controller for the branch predictor. It owns a pattern history table (PHT) of 2-bit saturating counters and sequences three things: IF-stage lookup and prediction, ID-stage resolution and update, and the post-reset table initialisation sweep. It produces the next-PC selection and the misprediction flush for the fetch path. It replaces the fixed always-taken policy with table-driven prediction.

Parameters:
IDX_W, 4, PHT index width; table has 2^IDX_W entries, index = if_pc[IDX_W+1:2]
INIT_CNT, 2'b10, counter value written by the init sweep (weakly taken)
CNT_W, 16, width of statistics counters (used only with BP_STATS_EN)

Ports:
clk  in  1  clock
rst  in  1  reset: one clock; reset is synchronous and active-high
stall  in  1  pipeline stall; freezes capture, update and flush
if_branch  in  1  a branch instruction is in IF
if_pc  in  32  PC of the IF instruction
if_pc_add_imm  in  32  taken target of the IF branch
id_branch  in  1  the branch recorded at IF is now resolving in ID
id_taken  in  1  actual outcome in ID (1 = taken)
pred_taken  out  1  prediction for the current IF branch
next_pc  out  32  PC for fetch next cycle
mispredict  out  1  flush IF/ID this cycle
busy  out  1  init sweep in progress
mispred_cnt  out  CNT_W  saturating misprediction count (BP_STATS_EN only)
branch_cnt  out  CNT_W  saturating resolved-branch count (BP_STATS_EN only)

Behaviour:
- FSM states: INIT and RUN. Reset enters INIT with sweep pointer 0. Each INIT cycle writes INIT_CNT to PHT[ptr] and increments ptr. The cycle that writes entry 2^IDX_W-1 moves the FSM to RUN, so INIT lasts exactly 2^IDX_W cycles. Reset asserted mid-operation restarts INIT.
- Reset values: busy=1, pred_taken=0, mispredict=0, stats=0, record and pending-update registers invalid.
- INIT behaviour: busy=1, pred_taken=0, next_pc=if_pc+4, mispredict=0. IF capture and ID updates are ignored. stall does not pause the sweep.
- Lookup (RUN, combinational): ctr = PHT[idx]. If a pending update targets the same idx, ctr uses the pending value (bypass). pred_taken = if_branch & ctr[1].
- Record (IF capture): on a RUN cycle with if_branch & ~stall & ~mispredict, register rec_valid=1, rec_idx, rec_pred=pred_taken, rec_ctr=ctr, and rec_alt. rec_alt = if_pc+4 if predicted taken, else if_pc_add_imm.
- Resolve: active when RUN & id_branch & ~stall & rec_valid.
  - mispredict = (rec_pred != id_taken), combinational, same cycle.
  - The new counter value is rec_ctr +1 if taken (saturates at 3) or -1 if not taken (saturates at 0). It is latched into the pending register and written to the PHT on the next cycle, one write per cycle.
  - rec_valid clears unless a new capture happens in the same cycle.
- id_branch with rec_valid=0: ignored, mispredict=0, no update.
- next_pc priority (RUN):
  1. mispredict -> rec_alt
  2. pred_taken -> if_pc_add_imm
  3. otherwise -> if_pc+4
  With stall=1, next_pc = if_pc+4 and mispredict=0; the fetch path holds the PC.
- Simultaneous IF and ID activity:
  - Correct resolve plus if_branch: update and new capture both occur.
  - Mispredict plus if_branch: capture is suppressed (wrong path) and rec_valid=0.
- PC arithmetic is 32-bit modulo; wrap-around is not flagged.

Optional Feature:
BP_STATS_EN:
- Defined: ports mispred_cnt and branch_cnt are present.
  - branch_cnt increments on every resolve.
  - mispred_cnt increments on every mispredict.
  - Both saturate at all-ones and clear on rst.
- Undefined: both ports and their counters are absent, and all other behaviour is identical.

Test Plan:
1. Reset with IDX_W=4, then hold rst=0 -> busy=1 for exactly 16 cycles, then 0; every PHT entry reads 2'b10.
2. In RUN, if_branch=1, if_pc=0x40, if_pc_add_imm=0x80 -> pred_taken=1, next_pc=0x80. Next cycle id_branch=1, id_taken=0 -> mispredict=1, next_pc=0x44; PHT[0] becomes 2'b01.
3. Same branch resolved not-taken three times -> counter goes 10->01->00->00 (saturates); the fourth lookup gives pred_taken=0 and next_pc=if_pc+4.
4. Resolve updates idx 5; in the very next cycle IF looks up idx 5 -> prediction uses the bypassed pending value, not the stale PHT.
5. stall=1 during an ID resolve with a would-be mispredict -> mispredict=0, no PHT change, record kept; the same resolve after stall drops produces the flush.
6. Mispredict in the same cycle as if_branch -> no new record; a following id_branch gives mispredict=0. With BP_STATS_EN, 5 resolves including 2 mispredicts -> branch_cnt=5, mispred_cnt=2.
